// File: rtl/topo_pkg.sv
// Shared definitions for the whack-a-mole grid controller.
//   - Colour codes driven per cell to the VGA renderer.
//   - Spawn LFSR taps and its next-state helper.
//   - Per-cell timer widths.
package topo_pkg;

    localparam logic [2:0] RGB_GREEN  = 3'b010;
    localparam logic [2:0] RGB_YELLOW = 3'b110;
    localparam logic [2:0] RGB_BLUE   = 3'b001;
    localparam logic [2:0] RGB_RED    = 3'b100;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting towards the MSB:
    // feedback is the XOR of state bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int LIFE_W  = 8;
    localparam int FLASH_W = 3;
    localparam int SPAWN_W = 8;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/topo_cell_timer.sv
// One mole cell: presence flag, lifetime counter and post-hit flash counter.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   tick          timebase strobe; both counters only move on tick
//   place         place a mole here (ignored if a mole is already present)
//   strike        strike this cell (acts only if a mole is present)
//   present       registered mole-present flag
//   expire        combinational: the mole runs out of life at this edge
//   flashing      registered: flash counter non-zero
module topo_cell_timer
    import topo_pkg::*;
#(
    parameter int LIFE_TICKS  = 60,
    parameter int FLASH_TICKS = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic place,
    input  logic strike,
    output logic present,
    output logic expire,
    output logic flashing
);

    logic               present_q, present_d;
    logic [LIFE_W-1:0]  life_q, life_d;
    logic [FLASH_W-1:0] flash_q, flash_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            present_q <= 1'b0;
            life_q    <= '0;
            flash_q   <= '0;
        end else begin
            present_q <= present_d;
            life_q    <= life_d;
            flash_q   <= flash_d;
        end
    end

    always_comb begin
        present_d = present_q;
        life_d    = life_q;
        flash_d   = flash_q;
        expire    = 1'b0;

        if (tick && flash_q != '0) begin
            flash_d = flash_q - 1'b1;
        end

        // A strike takes precedence over expiry in the same cycle, so a
        // mole on its last tick still counts as hit rather than escaped.
        if (strike && present_q) begin
            present_d = 1'b0;
            life_d    = '0;
            flash_d   = FLASH_W'(FLASH_TICKS);
        end else if (place && !present_q) begin
            present_d = 1'b1;
            life_d    = LIFE_W'(LIFE_TICKS);
        end else if (present_q && tick && life_q != '0) begin
            life_d = life_q - 1'b1;
            if (life_q == LIFE_W'(1)) begin
                present_d = 1'b0;
                expire    = 1'b1;
            end
        end
    end

    assign present  = present_q;
    assign flashing = (flash_q != '0);

endmodule

// File: rtl/topo_grid_ctrl.sv
// Whack-a-mole grid controller: N_CELLS timed mole cells, selection cursor,
// strike resolution, saturating score, pseudo-random spawning and a per-cell
// 3-bit colour code for the VGA renderer.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   tick                  timebase strobe for all timers
//   move_next, move_prev  cursor step pulses (both together: no move)
//   golpe                 strike at the current cursor
//   place_en, place_idx   external placement request (out-of-range ignored)
//   cursor                selected cell
//   topo                  mole-present vector
//   hit, miss, escape     registered one-cycle event pulses
//   score                 saturating hit count
//   rgb                   cell i colour at [3i+2:3i], combinational
module topo_grid_ctrl
    import topo_pkg::*;
#(
    parameter int          N_CELLS     = 9,
    parameter int          SEL_W       = 4,
    parameter int          LIFE_TICKS  = 60,
    parameter int          SPAWN_TICKS = 30,
    parameter int          FLASH_TICKS = 3,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   move_next,
    input  logic                   move_prev,
    input  logic                   golpe,
    input  logic                   place_en,
    input  logic [SEL_W-1:0]       place_idx,
    output logic [SEL_W-1:0]       cursor,
    output logic [N_CELLS-1:0]     topo,
    output logic                   hit,
    output logic                   miss,
    output logic                   escape,
    output logic [SCORE_W-1:0]     score,
    output logic [3*N_CELLS-1:0]   rgb
);

    localparam logic [SEL_W-1:0]   LAST_CELL  = SEL_W'(N_CELLS - 1);
    localparam logic [SEL_W:0]     N_CELLS_X  = (SEL_W + 1)'(N_CELLS);
    localparam logic [15:0]        LFSR_MOD   = 16'(N_CELLS);
    localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_TICKS - 1);

    logic [SEL_W-1:0]   cursor_q, cursor_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [SPAWN_W-1:0] spawn_q, spawn_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               escape_q, escape_d;

    logic [N_CELLS-1:0] present;
    logic [N_CELLS-1:0] expire;
    logic [N_CELLS-1:0] flashing;
    logic [N_CELLS-1:0] strike_v;
    logic [N_CELLS-1:0] place_v;

    logic               spawn_try;
    logic [SEL_W-1:0]   spawn_idx;
    logic               ext_ok;
    logic               tgt_valid;
    logic [SEL_W-1:0]   tgt_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cursor_q <= '0;
            lfsr_q   <= LFSR_SEED;
            spawn_q  <= '0;
            score_q  <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            escape_q <= 1'b0;
        end else begin
            cursor_q <= cursor_d;
            lfsr_q   <= lfsr_d;
            spawn_q  <= spawn_d;
            score_q  <= score_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            escape_q <= escape_d;
        end
    end

    always_comb begin
        cursor_d = cursor_q;
        if (move_next && !move_prev) begin
            cursor_d = (cursor_q == LAST_CELL) ? '0 : cursor_q + 1'b1;
        end else if (move_prev && !move_next) begin
            cursor_d = (cursor_q == '0) ? LAST_CELL : cursor_q - 1'b1;
        end
    end

    assign lfsr_d = lfsr_next(lfsr_q);

    always_comb begin
        spawn_d   = spawn_q;
        spawn_try = 1'b0;
        if (tick) begin
            if (spawn_q == SPAWN_LAST) begin
                spawn_d   = '0;
                spawn_try = 1'b1;
            end else begin
                spawn_d = spawn_q + 1'b1;
            end
        end
    end

    assign spawn_idx = SEL_W'(lfsr_q % LFSR_MOD);

    // External placement wins over the automatic attempt; out-of-range
    // indices are dropped entirely and do not block the automatic one.
    assign ext_ok    = place_en && ({1'b0, place_idx} < N_CELLS_X);
    assign tgt_valid = ext_ok || spawn_try;
    assign tgt_idx   = ext_ok ? place_idx : spawn_idx;

    // Placement requires an empty cell before the edge; a cell being struck
    // is still present here, so it reads as occupied.
    always_comb begin
        strike_v = '0;
        place_v  = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            strike_v[i] = golpe && (cursor_q == SEL_W'(i)) && present[i];
            place_v[i]  = tgt_valid && (tgt_idx == SEL_W'(i)) && !present[i];
        end
    end

    for (genvar g = 0; g < N_CELLS; g++) begin : g_cell
        topo_cell_timer #(
            .LIFE_TICKS  (LIFE_TICKS),
            .FLASH_TICKS (FLASH_TICKS)
        ) u_cell (
            .clock    (clock),
            .reset    (reset),
            .tick     (tick),
            .place    (place_v[g]),
            .strike   (strike_v[g]),
            .present  (present[g]),
            .expire   (expire[g]),
            .flashing (flashing[g])
        );
    end

    assign hit_d    = |strike_v;
    assign miss_d   = golpe && !hit_d;
    assign escape_d = |expire;

    always_comb begin
        score_d = score_q;
        if (hit_d && score_q != '1) begin
            score_d = score_q + 1'b1;
        end
    end

    always_comb begin
        rgb = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (cursor_q == SEL_W'(i)) begin
                rgb[3*i +: 3] = RGB_YELLOW;
            end else if (flashing[i]) begin
                rgb[3*i +: 3] = RGB_RED;
            end else if (present[i]) begin
                rgb[3*i +: 3] = RGB_BLUE;
            end else begin
                rgb[3*i +: 3] = RGB_GREEN;
            end
        end
    end

    assign cursor = cursor_q;
    assign topo   = present;
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign escape = escape_q;
    assign score  = score_q;

endmodule

// File: tb/tb_topo_grid_ctrl.sv
module tb_topo_grid_ctrl;

    localparam int N = 9;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        move_next = 1'b0;
    logic        move_prev = 1'b0;
    logic        golpe = 1'b0;
    logic        place_en = 1'b0;
    logic [3:0]  place_idx = '0;
    logic [3:0]  cursor;
    logic [8:0]  topo;
    logic        hit, miss, escape;
    logic [7:0]  score;
    logic [26:0] rgb;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    topo_grid_ctrl #(
        .N_CELLS     (N),
        .SEL_W       (4),
        .LIFE_TICKS  (4),
        .SPAWN_TICKS (200),
        .FLASH_TICKS (2),
        .SCORE_W     (8),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .move_next (move_next),
        .move_prev (move_prev),
        .golpe     (golpe),
        .place_en  (place_en),
        .place_idx (place_idx),
        .cursor    (cursor),
        .topo      (topo),
        .hit       (hit),
        .miss      (miss),
        .escape    (escape),
        .score     (score),
        .rgb       (rgb)
    );

    typedef struct {
        logic       mn, mp, g, pe;
        logic [3:0] pi;
        logic       tk;
        logic [3:0] cur;
        logic [8:0] tp;
        logic       h, m, e;
        logic [7:0] sc;
        logic [2:0] c3;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic void add(input logic mn, mp, g, pe, input logic [3:0] pi,
                                input logic tk, input logic [3:0] cur, input logic [8:0] tp,
                                input logic h, m, e, input logic [7:0] sc, input logic [2:0] c3);
        vec_t v;
        v.mn = mn; v.mp = mp; v.g = g; v.pe = pe; v.pi = pi; v.tk = tk;
        v.cur = cur; v.tp = tp; v.h = h; v.m = m; v.e = e; v.sc = sc; v.c3 = c3;
        vecs.push_back(v);
    endfunction

    function automatic void chk(input string name, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    endfunction

    task automatic cyc(input logic mn, mp, g, pe, input logic [3:0] pi, input logic tk);
        move_next = mn; move_prev = mp; golpe = g;
        place_en = pe; place_idx = pi; tick = tk;
        @(posedge clock);
        #1;
        move_next = 0; move_prev = 0; golpe = 0; place_en = 0; place_idx = 0; tick = 0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    logic [26:0] exp_rgb;
    vec_t e;

    initial begin
        //   mn mp g pe pi  tk | cur topo   h m e sc c3
        add(0, 1, 0, 0, 0,  0,   8, 9'h000, 0,0,0, 0, 3'b010);
        add(1, 0, 0, 0, 0,  0,   0, 9'h000, 0,0,0, 0, 3'b010);
        add(1, 1, 0, 0, 0,  0,   0, 9'h000, 0,0,0, 0, 3'b010);
        add(0, 0, 0, 1, 3,  0,   0, 9'h008, 0,0,0, 0, 3'b001);
        add(1, 0, 0, 0, 0,  0,   1, 9'h008, 0,0,0, 0, 3'b001);
        add(1, 0, 0, 0, 0,  0,   2, 9'h008, 0,0,0, 0, 3'b001);
        add(0, 0, 1, 0, 0,  0,   2, 9'h008, 0,1,0, 0, 3'b001);
        add(1, 0, 0, 0, 0,  0,   3, 9'h008, 0,0,0, 0, 3'b110);
        add(0, 0, 1, 0, 0,  0,   3, 9'h000, 1,0,0, 1, 3'b110);
        add(1, 0, 0, 0, 0,  0,   4, 9'h000, 0,0,0, 1, 3'b100);
        add(0, 0, 0, 0, 0,  1,   4, 9'h000, 0,0,0, 1, 3'b100);
        add(0, 0, 0, 0, 0,  1,   4, 9'h000, 0,0,0, 1, 3'b010);
        add(0, 0, 0, 1, 5,  0,   4, 9'h020, 0,0,0, 1, 3'b010);
        add(0, 0, 0, 0, 0,  1,   4, 9'h020, 0,0,0, 1, 3'b010);
        add(0, 0, 0, 0, 0,  1,   4, 9'h020, 0,0,0, 1, 3'b010);
        add(0, 0, 0, 0, 0,  1,   4, 9'h020, 0,0,0, 1, 3'b010);
        add(0, 0, 0, 0, 0,  1,   4, 9'h000, 0,0,1, 1, 3'b010);
        add(0, 0, 0, 0, 0,  0,   4, 9'h000, 0,0,0, 1, 3'b010);
        add(0, 0, 0, 1, 7,  0,   4, 9'h080, 0,0,0, 1, 3'b010);
        add(0, 0, 0, 1, 7,  0,   4, 9'h080, 0,0,0, 1, 3'b010);
        add(0, 0, 0, 1, 12, 0,   4, 9'h080, 0,0,0, 1, 3'b010);
        add(1, 0, 0, 0, 0,  1,   5, 9'h080, 0,0,0, 1, 3'b010);
        add(1, 0, 0, 0, 0,  1,   6, 9'h080, 0,0,0, 1, 3'b010);
        add(1, 0, 0, 0, 0,  1,   7, 9'h080, 0,0,0, 1, 3'b010);
        add(0, 0, 1, 0, 0,  1,   7, 9'h000, 1,0,0, 2, 3'b010);
        add(0, 0, 0, 0, 0,  0,   7, 9'h000, 0,0,0, 2, 3'b010);

        exp_rgb = {8{3'b010}} << 3;
        exp_rgb[2:0] = 3'b110;

        // Initial reset
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cursor", 0, 32'(cursor), 32'd0);
        chk("rst_topo",   0, 32'(topo),   32'd0);
        chk("rst_score",  0, 32'(score),  32'd0);
        chk("rst_pulses", 0, 32'({hit, miss, escape}), 32'd0);
        chk("rst_rgb",    0, 32'(rgb),    32'(exp_rgb));
        reset = 1'b0;

        // Table-driven sequence through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            move_next = vecs[i].mn; move_prev = vecs[i].mp; golpe = vecs[i].g;
            place_en = vecs[i].pe; place_idx = vecs[i].pi; tick = vecs[i].tk;
            sb.push_back(vecs[i]);
            @(posedge clock);
            #1;
            move_next = 0; move_prev = 0; golpe = 0; place_en = 0; place_idx = 0; tick = 0;
            e = sb.pop_front();
            chk("cursor", i, 32'(cursor), 32'(e.cur));
            chk("topo",   i, 32'(topo),   32'(e.tp));
            chk("hit",    i, 32'(hit),    32'(e.h));
            chk("miss",   i, 32'(miss),   32'(e.m));
            chk("escape", i, 32'(escape), 32'(e.e));
            chk("score",  i, 32'(score),  32'(e.sc));
            chk("rgb3",   i, 32'(rgb[11:9]), 32'(e.c3));
        end

        // Three more hits at cursor 7 to reach score 5
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 7, 0);
            cyc(0, 0, 1, 0, 0, 0);
            chk("hit7", k, 32'(hit), 32'd1);
            chk("score7", k, 32'(score), 32'(3 + k));
        end

        // Asynchronous reset mid-cycle: outputs clear before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("arst_topo",   0, 32'(topo),   32'd0);
        chk("arst_score",  0, 32'(score),  32'd0);
        chk("arst_cursor", 0, 32'(cursor), 32'd0);
        chk("arst_rgb",    0, 32'(rgb),    32'(exp_rgb));
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_score", 0, 32'(score), 32'd0);
        chk("post_rst_cursor", 0, 32'(cursor), 32'd0);

        // Score saturation at 255
        for (int k = 1; k <= 255; k++) begin
            cyc(0, 0, 0, 1, 0, 0);
            cyc(0, 0, 1, 0, 0, 0);
            if (k == 1 || k == 255) chk("sat_score", k, 32'(score), 32'(k));
        end
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("sat_hit",   0, 32'(hit),   32'd1);
        chk("sat_score", 256, 32'(score), 32'd255);
        cyc(0, 0, 1, 0, 0, 0);
        chk("sat_miss",  0, 32'(miss),  32'd1);
        chk("sat_score", 257, 32'(score), 32'd255);

        // Automatic spawn: no attempt over 199 ticks, one mole on the 200th
        pulse_reset();
        for (int k = 0; k < 199; k++) cyc(0, 0, 0, 0, 0, 1);
        chk("spawn_early", 0, 32'(topo), 32'd0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("spawn_one", 0, 32'($countones(topo)), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/topo_grid_ctrl.md
Name: topo_grid_ctrl

Overview:
- Parametrised whack-a-mole grid controller for the VGA game.
- Holds state for N_CELLS mole cells and places moles pseudo-randomly or on external command; each mole has a lifetime.
- Moves a selection cursor, resolves hits and misses, keeps a saturating score, and drives a 3-bit RGB code per cell to the VGA renderer.
- Supersedes the single combinational cell with registered, timed per-cell state.

Parameters:
- N_CELLS, 9, number of mole cells (2..16).
- SEL_W, 4, cursor/index width; must satisfy 2^SEL_W >= N_CELLS.
- LIFE_TICKS, 60, ticks a mole stays before escaping (1..255).
- SPAWN_TICKS, 30, ticks between automatic spawn attempts (1..255).
- FLASH_TICKS, 3, ticks a cell shows red after a hit (1..7).
- SCORE_W, 8, score counter width.
- LFSR_SEED, 16'hACE1, non-zero reset value of the spawn LFSR.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timebase pulse (frame strobe); all timers count only on tick.
- move_next  in  1  one-cycle pulse; cursor +1.
- move_prev  in  1  one-cycle pulse; cursor -1.
- golpe  in  1  one-cycle strike pulse at the current cursor.
- place_en  in  1  external mole placement request.
- place_idx  in  SEL_W  target cell for place_en.
- cursor  out  SEL_W  current selected cell.
- topo  out  N_CELLS  bit i = mole present in cell i.
- hit  out  1  one-cycle pulse on successful strike.
- miss  out  1  one-cycle pulse on strike at an empty cell.
- escape  out  1  one-cycle pulse when any mole expires.
- score  out  SCORE_W  saturating hit count.
- rgb  out  3*N_CELLS  cell i colour at bits [3i+2:3i].

Behaviour:
- Reset (async): topo=0, cursor=0, all life and flash counters 0, spawn counter 0, score=0, hit/miss/escape=0, LFSR=LFSR_SEED. Release is synchronous to the next clock edge.
- Cursor:
  - move_next alone: cursor = (cursor==N_CELLS-1) ? 0 : cursor+1.
  - move_prev alone: wraps 0 -> N_CELLS-1.
  - Both asserted: no move.
- Strike:
  - golpe evaluates the pre-edge cursor and topo.
  - If topo[cursor]=1: clear the mole; hit=1 next cycle; score+1, saturating at all-ones; flash[cursor]=FLASH_TICKS.
  - Otherwise miss=1 and score is unchanged.
  - Pulses are registered, so latency is 1 cycle.
- Life:
  - On placement, life[i]=LIFE_TICKS.
  - On tick with topo[i]=1, life[i] decrements. On reaching 0 the mole clears and escape=1 (OR over all cells).
  - Strike and expiry in the same cycle on the same cell: the strike wins; hit, no escape.
- Spawn:
  - The LFSR (x^16+x^14+x^13+x^11+1) advances every clock.
  - On tick, spawn_cnt increments. When it reaches SPAWN_TICKS-1 it wraps to 0 and an attempt targets idx = lfsr % N_CELLS.
  - place_en with place_idx<N_CELLS requests placement at place_idx; place_idx>=N_CELLS is ignored.
  - place_en overrides an automatic attempt in the same cycle.
  - Placement applies only if the target is empty pre-edge; an occupied target is skipped with no retry. A cell being struck this cycle counts as occupied.
- Flash: on tick, a non-zero flash[i] decrements.
- Colour per cell, in priority order:
  - cursor==i: 110 (yellow)
  - flash[i]!=0: 100 (red)
  - topo[i]: 001 (blue)
  - otherwise: 010 (green)
- All outputs are registered except rgb, which is combinational from registered state.

Decomposition:
- Shared package topo_pkg holds colour constants (RGB_GREEN=3'b010, RGB_YELLOW=3'b110, RGB_BLUE=3'b001, RGB_RED=3'b100) and LFSR taps.
- One natural sub-module, topo_cell_timer, instantiated N_CELLS times. Each instance holds topo, life and flash, with inputs place, strike, tick and outputs present, expire, flashing.
- The top level holds cursor, LFSR, spawn counter, score and colour mux.

Test Plan (N_CELLS=9, LIFE_TICKS=4, SPAWN_TICKS=200, FLASH_TICKS=2):
- Assert reset mid-run with score=5 -> same cycle: topo=0, score=0, cursor=0, rgb cell0=110, others=010.
- At cursor=0, pulse move_prev -> cursor=8. Pulse move_next -> 0. Pulse both together -> stays 0.
- place_en idx=3; move cursor to 3; golpe -> hit=1 for one cycle, score=1, topo[3]=0. Move cursor away -> cell3 rgb=100 for 2 ticks, then 010.
- place_en idx=5; issue 4 ticks with no golpe -> escape=1 on the 4th-tick edge, topo[5]=0, score unchanged.
- golpe at empty cursor=2 -> miss=1, score unchanged. With score=255 (SCORE_W=8), a further hit leaves score=255.
- place idx=7 with life=1; cursor=7; golpe and tick in the same cycle -> hit=1, escape=0. place_en idx=7 while topo[7]=1 -> no change. place_idx=12 -> ignored.
